// File: rtl/framebuf_swap.sv
// Double-buffered frame store: the core fills the back bank, video reads the front bank,
// and the banks swap at the start of vertical blank once a completed frame is pending.
module framebuf_swap #(
   parameter int XW = 8,
   parameter int YW = 8,
   parameter int DW = 8
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [XW-1:0] wr_x,
   input  logic [YW-1:0] wr_y,
   input  logic [DW-1:0] wr_data,
   input  logic          frame,
   input  logic          ce_pix,
   input  logic          vb,
   input  logic          de,
   input  logic [XW-1:0] rd_x,
   input  logic [YW-1:0] rd_y,
   output logic [DW-1:0] rgb_out,
   output logic          busy,
   output logic          front_bank,
   output logic [7:0]    drop_cnt
);
   localparam int AW = XW + YW + 1;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;
   logic          busy_q, busy_d;
   logic          front_q, front_d;
   logic          pending_q, pending_d;
   logic [7:0]    drop_q, drop_d;
   logic          frame_prev_q, frame_prev_d;
   logic          vb_prev_q, vb_prev_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          rd_v1_q, rd_v1_d, rd_v2_q, rd_v2_d;
   logic          rd_de1_q, rd_de1_d, rd_de2_q, rd_de2_d;
   logic [DW-1:0] rgb_q, rgb_d;
   logic [DW-1:0] mem_rd_q;
   logic [DW-1:0] mem_q [2**AW];

   logic          frame_rise, vb_rise;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;

   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      busy_d       = busy_q;
      front_d      = front_q;
      pending_d    = pending_q;
      drop_d       = drop_q;
      frame_prev_d = frame;
      vb_prev_d    = vb;
      frame_rise   = frame & ~frame_prev_q;
      vb_rise      = vb & ~vb_prev_q;
      mem_we       = 1'b0;
      mem_waddr    = {~front_q, wr_y, wr_x};
      mem_wdata    = wr_data;

      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
               state_d = ST_RUN;
               busy_d  = 1'b0;
            end
         end
         default: begin
            mem_we = wr_en;
            // A frame completing on the vblank edge is shown at once, so no drop.
            if (vb_rise && (pending_q || frame_rise)) begin
               front_d   = ~front_q;
               pending_d = 1'b0;
            end else if (frame_rise) begin
               pending_d = 1'b1;
               if (pending_q && drop_q != 8'hFF)
                  drop_d = drop_q + 8'd1;
            end
         end
      endcase

      rd_addr_d = ce_pix ? {front_q, rd_y, rd_x} : rd_addr_q;
      rd_de1_d  = ce_pix ? de : rd_de1_q;
      rd_v1_d   = ce_pix;
      rd_v2_d   = rd_v1_q;
      rd_de2_d  = rd_de1_q;
      rgb_d     = rgb_q;
      if (state_q == ST_CLEAR)
         rgb_d = '0;
      else if (rd_v2_q)
         rgb_d = rd_de2_q ? mem_rd_q : '0;
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q      <= ST_CLEAR;
         clr_cnt_q    <= '0;
         busy_q       <= 1'b1;
         front_q      <= 1'b0;
         pending_q    <= 1'b0;
         drop_q       <= '0;
         frame_prev_q <= frame;
         vb_prev_q    <= vb;
         rd_addr_q    <= '0;
         rd_v1_q      <= 1'b0;
         rd_v2_q      <= 1'b0;
         rd_de1_q     <= 1'b0;
         rd_de2_q     <= 1'b0;
         rgb_q        <= '0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         busy_q       <= busy_d;
         front_q      <= front_d;
         pending_q    <= pending_d;
         drop_q       <= drop_d;
         frame_prev_q <= frame_prev_d;
         vb_prev_q    <= vb_prev_d;
         rd_addr_q    <= rd_addr_d;
         rd_v1_q      <= rd_v1_d;
         rd_v2_q      <= rd_v2_d;
         rd_de1_q     <= rd_de1_d;
         rd_de2_q     <= rd_de2_d;
         rgb_q        <= rgb_d;
      end
   end

   // Frame memory: no reset, contents are cleared by the CLEAR sweep instead.
   always_ff @(posedge clk_sys) begin
      if (mem_we)
         mem_q[mem_waddr] <= mem_wdata;
      mem_rd_q <= mem_q[rd_addr_q];
   end

   assign rgb_out    = rgb_q;
   assign busy       = busy_q;
   assign front_bank = front_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_framebuf_swap.sv
// Self-checking bench for framebuf_swap: random stimulus compared against a
// frame-level model of the two banks, swap rule and drop counter.
module tb_framebuf_swap;
   localparam int XW   = 4;
   localparam int YW   = 4;
   localparam int DW   = 8;
   localparam int NCLR = 2 ** (XW + YW + 1);

   logic          clk_sys = 1'b0;
   logic          reset_n, wr_en, frame, ce_pix, vb, de;
   logic [XW-1:0] wr_x, rd_x;
   logic [YW-1:0] wr_y, rd_y;
   logic [DW-1:0] wr_data, rgb_out;
   logic          busy, front_bank;
   logic [7:0]    drop_cnt;

   int n_chk = 0;
   int n_pass = 0;

   framebuf_swap #(.XW(XW), .YW(YW), .DW(DW)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .frame(frame), .ce_pix(ce_pix), .vb(vb), .de(de),
      .rd_x(rd_x), .rd_y(rd_y), .rgb_out(rgb_out), .busy(busy),
      .front_bank(front_bank), .drop_cnt(drop_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   // Reference model: two plain pixel arrays plus swap bookkeeping.
   logic [7:0] m_mem [0:1][0:255];
   int         m_clear_left = NCLR;
   int         m_drop = 0;
   logic       m_front = 1'b0, m_pending = 1'b0;
   logic       m_frame_prev = 1'b0, m_vb_prev = 1'b0;
   logic       m_fr, m_vr;

   always @(posedge clk_sys) begin
      if (!reset_n) begin
         m_clear_left = NCLR;
         m_front = 1'b0;
         m_pending = 1'b0;
         m_drop = 0;
         for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++)
               m_mem[b][a] = 8'h00;
      end else if (m_clear_left > 0) begin
         m_clear_left--;
      end else begin
         m_fr = frame && !m_frame_prev;
         m_vr = vb && !m_vb_prev;
         if (wr_en)
            m_mem[m_front ? 0 : 1][{wr_y, wr_x}] = wr_data;
         if (m_vr && (m_pending || m_fr)) begin
            m_front = !m_front;
            m_pending = 1'b0;
         end else if (m_fr) begin
            if (m_pending && m_drop < 255)
               m_drop++;
            m_pending = 1'b1;
         end
      end
      m_frame_prev = frame;
      m_vb_prev = vb;
   end

   function automatic logic [7:0] exp_rd(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                         input logic d);
      return d ? m_mem[m_front ? 1 : 0][{y, x}] : 8'h00;
   endfunction

   task automatic nb();
      @(negedge clk_sys);
      wr_en = 1'b0;
      ce_pix = 1'b0;
   endtask

   task automatic do_write(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [7:0] d);
      nb();
      wr_en = 1'b1; wr_x = x; wr_y = y; wr_data = d;
   endtask

   task automatic pulse_frame();
      nb(); frame = 1'b1;
      nb(); frame = 1'b0;
   endtask

   task automatic pulse_vb();
      nb(); vb = 1'b1;
      nb(); vb = 1'b0;
   endtask

   task automatic do_read(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic d,
                          output logic [7:0] got);
      nb(); ce_pix = 1'b1; rd_x = x; rd_y = y; de = d;
      nb(); nb(); nb();
      got = rgb_out;
   endtask

   task automatic wait_clear(input string name);
      int cnt = 0;
      while (busy === 1'b1 && cnt < 2 * NCLR) begin
         nb();
         cnt++;
         if (busy === 1'b1) begin
            wr_en = 1'($urandom); wr_x = 4'($urandom); wr_y = 4'($urandom);
            wr_data = 8'($urandom); frame = 1'($urandom); vb = 1'($urandom);
         end
      end
      frame = 1'b0; vb = 1'b0;
      n_chk++;
      if (cnt !== NCLR) $display("FAIL %s busy_len got=%0d exp=%0d", name, cnt, NCLR);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; frame = 1'b1; vb = 1'b1;
      nb(); nb();
      n_chk++;
      if ({busy, front_bank, drop_cnt, rgb_out} !== {1'b1, 1'b0, 8'h00, 8'h00})
         $display("FAIL reset_state busy=%b front=%b drop=%0d rgb=%h exp 1 0 0 00",
                  busy, front_bank, drop_cnt, rgb_out);
      else n_pass++;
      reset_n = 1'b1;
      wait_clear("reset");
      nb();
      n_chk++;
      if (busy !== 1'b0) $display("FAIL busy_after_clear got=%b exp=0", busy);
      else n_pass++;
   endtask

   task automatic test_clear_zero();
      logic [7:0] got;
      for (int i = 0; i < 6; i++) begin
         logic [XW-1:0] x = 4'($urandom);
         logic [YW-1:0] y = 4'($urandom);
         do_read(x, y, 1'b1, got);
         n_chk++;
         if (got !== 8'h00) $display("FAIL clear_zero (%0d,%0d) got=%h exp=00", x, y, got);
         else n_pass++;
      end
   endtask

   task automatic test_write_swap();
      logic [7:0] old;
      do_write(4'd5, 4'd7, 8'hE3);
      pulse_frame();
      pulse_vb();
      nb();
      n_chk++;
      if (front_bank !== 1'b1 || m_front !== 1'b1)
         $display("FAIL swap_front got=%b exp=1", front_bank);
      else n_pass++;
      old = rgb_out;
      ce_pix = 1'b1; rd_x = 4'd5; rd_y = 4'd7; de = 1'b1;
      nb(); nb();
      n_chk++;
      if (rgb_out !== old) $display("FAIL read_latency_hold got=%h exp=%h", rgb_out, old);
      else n_pass++;
      nb();
      n_chk++;
      if (rgb_out !== 8'hE3) $display("FAIL read_after_swap got=%h exp=e3", rgb_out);
      else n_pass++;
   endtask

   task automatic test_no_frame();
      logic [7:0] got;
      logic       f0 = front_bank;
      do_write(4'd5, 4'd7, 8'h5A);
      pulse_vb();
      nb();
      n_chk++;
      if (front_bank !== f0) $display("FAIL no_frame_swap got=%b exp=%b", front_bank, f0);
      else n_pass++;
      do_read(4'd5, 4'd7, 1'b1, got);
      n_chk++;
      if (got !== 8'hE3) $display("FAIL no_frame_read got=%h exp=e3", got);
      else n_pass++;
   endtask

   task automatic test_drops();
      logic f0 = front_bank;
      pulse_frame(); pulse_frame(); pulse_frame();
      nb();
      n_chk++;
      if (drop_cnt !== 8'd2) $display("FAIL drop_cnt got=%0d exp=2", drop_cnt);
      else n_pass++;
      pulse_vb();
      nb();
      n_chk++;
      if (front_bank !== ~f0) $display("FAIL drop_swap_once got=%b exp=%b", front_bank, ~f0);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      logic [7:0]    got;
      logic          f0 = front_bank;
      logic [7:0]    d0 = drop_cnt;
      logic [XW-1:0] x = 4'($urandom);
      logic [YW-1:0] y = 4'($urandom);
      logic [7:0]    d = 8'($urandom_range(1, 255));
      nb();
      frame = 1'b1; vb = 1'b1;
      wr_en = 1'b1; wr_x = x; wr_y = y; wr_data = d;
      nb();
      frame = 1'b0; vb = 1'b0;
      n_chk++;
      if (front_bank !== ~f0 || drop_cnt !== d0)
         $display("FAIL simul_swap front=%b drop=%0d exp front=%b drop=%0d",
                  front_bank, drop_cnt, ~f0, d0);
      else n_pass++;
      do_read(x, y, 1'b1, got);
      n_chk++;
      if (got !== d) $display("FAIL simul_write_old_back got=%h exp=%h", got, d);
      else n_pass++;
      pulse_vb();
      nb();
      n_chk++;
      if (front_bank !== ~f0) $display("FAIL simul_pending_clear got=%b exp=%b", front_bank, ~f0);
      else n_pass++;
   endtask

   task automatic test_de_zero();
      logic [7:0] got;
      do_write(4'd9, 4'd3, 8'hFF);
      pulse_frame();
      pulse_vb();
      do_read(4'd9, 4'd3, 1'b0, got);
      n_chk++;
      if (got !== 8'h00) $display("FAIL de_zero got=%h exp=00", got);
      else n_pass++;
      do_read(4'd9, 4'd3, 1'b1, got);
      n_chk++;
      if (got !== 8'hFF) $display("FAIL de_one got=%h exp=ff", got);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q [$];
      logic [7:0] e;
      for (int i = 0; i < 40; i++)
         do_write(4'($urandom), 4'($urandom), 8'($urandom));
      pulse_frame();
      pulse_vb();
      for (int i = 0; i < 11; i++) begin
         nb();
         if (i >= 3) begin
            e = exp_q.pop_front();
            n_chk++;
            if (rgb_out !== e) $display("FAIL back_to_back[%0d] got=%h exp=%h", i - 3, rgb_out, e);
            else n_pass++;
         end
         if (i < 8) begin
            ce_pix = 1'b1; rd_x = 4'($urandom); rd_y = 4'($urandom); de = 1'($urandom);
            exp_q.push_back(exp_rd(rd_x, rd_y, de));
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] got, e;
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 4))
            0, 1: do_write(4'($urandom), 4'($urandom), 8'($urandom));
            2: pulse_frame();
            3: pulse_vb();
            default: begin
               logic [XW-1:0] x = 4'($urandom);
               logic [YW-1:0] y = 4'($urandom);
               logic          d = ($urandom_range(0, 3) != 0);
               nb();
               e = exp_rd(x, y, d);
               do_read(x, y, d, got);
               n_chk++;
               if (got !== e) $display("FAIL rand_read[%0d] (%0d,%0d) got=%h exp=%h", i, x, y, got, e);
               else n_pass++;
            end
         endcase
         nb();
         n_chk++;
         if (front_bank !== m_front || drop_cnt !== 8'(m_drop))
            $display("FAIL rand_state[%0d] front=%b drop=%0d exp front=%b drop=%0d",
                     i, front_bank, drop_cnt, m_front, m_drop);
         else n_pass++;
      end
   endtask

   task automatic test_drop_saturate();
      for (int i = 0; i < 260; i++) pulse_frame();
      nb();
      n_chk++;
      if (drop_cnt !== 8'd255) $display("FAIL drop_saturate got=%0d exp=255", drop_cnt);
      else n_pass++;
      pulse_vb();
   endtask

   task automatic test_mid_clear_reset();
      logic [7:0] got;
      reset_n = 1'b0;
      nb();
      reset_n = 1'b1;
      repeat (100) nb();
      reset_n = 1'b0;
      nb();
      n_chk++;
      if ({busy, front_bank, drop_cnt} !== {1'b1, 1'b0, 8'h00})
         $display("FAIL mid_reset_state busy=%b front=%b drop=%0d exp 1 0 0", busy, front_bank, drop_cnt);
      else n_pass++;
      reset_n = 1'b1;
      wait_clear("mid_clear");
      for (int i = 0; i < 4; i++) begin
         logic [XW-1:0] x = 4'($urandom);
         logic [YW-1:0] y = 4'($urandom);
         do_read(x, y, 1'b1, got);
         n_chk++;
         if (got !== 8'h00) $display("FAIL recleared (%0d,%0d) got=%h exp=00", x, y, got);
         else n_pass++;
      end
   endtask

   initial begin
      wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
      ce_pix = 1'b0; rd_x = '0; rd_y = '0; de = 1'b0;
      test_reset();
      test_clear_zero();
      test_write_swap();
      test_no_frame();
      test_drops();
      test_simultaneous();
      test_de_zero();
      test_back_to_back();
      test_random();
      test_drop_saturate();
      test_mid_clear_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule
